// File: rtl/div_issue_ctrl_if.sv
// ---------------------------------------------------------------------------
// div_issue_ctrl_if
//   Connection between the EX-stage divide issue controller and the
//   fixed-latency, level-start divider wrapper.
//
//   Signals
//     div_start    controller -> divider  level start, held high until done
//     div_unsigned controller -> divider  1 = unsigned divide (DIVU)
//     div_opa      controller -> divider  dividend (rs)
//     div_opb      controller -> divider  divisor (rt)
//     div_result   divider -> controller  {remainder, quotient}
//     div_done     divider -> controller  result valid this cycle
//
//   Modports
//     master  issue controller side
//     slave   divider side
// ---------------------------------------------------------------------------
interface div_issue_ctrl_if;
  logic        div_start;
  logic        div_unsigned;
  logic [31:0] div_opa;
  logic [31:0] div_opb;
  logic [63:0] div_result;
  logic        div_done;

  modport master (
    output div_start,
    output div_unsigned,
    output div_opa,
    output div_opb,
    input  div_result,
    input  div_done
  );

  modport slave (
    input  div_start,
    input  div_unsigned,
    input  div_opa,
    input  div_opb,
    output div_result,
    output div_done
  );
endinterface

// File: rtl/div_issue_ctrl.sv
// ---------------------------------------------------------------------------
// div_issue_ctrl
//   EX-stage initiator for a fixed-latency, level-start divider. A DIV/DIVU
//   request seen in IDLE latches its operands and raises div_start, which is
//   held until the divider reports done. The pipeline is stalled for the
//   whole run. The 64-bit {remainder, quotient} is captured into HI/LO
//   holding registers and offered on the HI/LO write port until MEM accepts
//   it (pipe_ready) or the instruction is flushed.
//
//   Parameters
//     DIV_CYCLES     cycles from the first start-high cycle to done; must
//                    match the divider
//     TIMEOUT_SLACK  extra BUSY cycles tolerated before the sticky timeout
//
//   Ports
//     clock, reset   clock; synchronous active-low reset
//     req_valid      EX holds a DIV/DIVU this cycle
//     req_unsigned   1 = DIVU, 0 = DIV
//     req_opa/opb    dividend / divisor
//     flush          kills the EX instruction
//     pipe_ready     EX output accepted by MEM this cycle
//     stall_req      hold IF/ID/EX (combinational)
//     hilo_we        write HI/LO this cycle (combinational)
//     hi_out/lo_out  remainder / quotient holding registers
//     busy           controller not in IDLE (combinational)
//     timeout        sticky: done not seen within the allowed window
//     div            divider connection (master side)
// ---------------------------------------------------------------------------
module div_issue_ctrl #(
  parameter int unsigned DIV_CYCLES    = 36,
  parameter int unsigned TIMEOUT_SLACK = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    req_valid,
  input  logic                    req_unsigned,
  input  logic [31:0]             req_opa,
  input  logic [31:0]             req_opb,
  input  logic                    flush,
  input  logic                    pipe_ready,
  output logic                    stall_req,
  output logic                    hilo_we,
  output logic [31:0]             hi_out,
  output logic [31:0]             lo_out,
  output logic                    busy,
  output logic                    timeout,
  div_issue_ctrl_if.master        div
);

  // BUSY-cycle count at which the run is declared overdue.
  localparam int unsigned LIMIT = DIV_CYCLES + TIMEOUT_SLACK;
  // One spare bit so the counter can saturate above LIMIT without wrapping
  // back onto it and re-triggering the compare.
  localparam int unsigned CNT_W = $clog2(LIMIT + 1) + 1;

  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t             state_r;
  state_t             next_state_s;

  logic               start_r;
  logic               div_unsigned_r;
  logic [31:0]        opa_r;
  logic [31:0]        opb_r;
  logic [31:0]        hi_r;
  logic [31:0]        lo_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               timeout_r;

  logic               stall_req_s;
  logic               hilo_we_s;
  logic               busy_s;

  // Issue request that actually starts a division this cycle.
  logic               issue_s;
  assign issue_s = req_valid && !flush;

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        // div_done here is stale and deliberately ignored.
        if (issue_s) begin
          next_state_s = ST_BUSY;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        // Flush wins over a coincident done: the result is discarded.
        if (flush) begin
          next_state_s = ST_IDLE;
        end else if (div.div_done) begin
          next_state_s = ST_HOLD;
        end else begin
          next_state_s = ST_BUSY;
        end
      end
      ST_HOLD: begin
        if (flush || pipe_ready) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_HOLD;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Pipeline-facing outputs decoded from the current state.
  always_comb begin
    stall_req_s = 1'b0;
    hilo_we_s   = 1'b0;
    busy_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // Stall in the request cycle itself so EX does not advance before
        // the divider has been started.
        stall_req_s = issue_s;
        hilo_we_s   = 1'b0;
        busy_s      = 1'b0;
      end
      ST_BUSY: begin
        stall_req_s = 1'b1;
        hilo_we_s   = 1'b0;
        busy_s      = 1'b1;
      end
      ST_HOLD: begin
        stall_req_s = 1'b0;
        hilo_we_s   = pipe_ready && !flush;
        busy_s      = 1'b1;
      end
      default: begin
        stall_req_s = 1'b0;
        hilo_we_s   = 1'b0;
        busy_s      = 1'b0;
      end
    endcase
  end

  // Divider drive, result capture, BUSY counter and timeout flag.
  always_ff @(posedge clock) begin
    if (!reset) begin
      start_r        <= 1'b0;
      div_unsigned_r <= 1'b0;
      opa_r          <= 32'd0;
      opb_r          <= 32'd0;
      hi_r           <= 32'd0;
      lo_r           <= 32'd0;
      cnt_r          <= {CNT_W{1'b0}};
      timeout_r      <= 1'b0;
    end else begin
      // Start is high exactly while the controller sits in BUSY, so it is
      // guaranteed low for at least the HOLD or flush cycle between runs and
      // the level-start divider always sees a clean restart.
      start_r <= (next_state_s == ST_BUSY);
      case (state_r)
        ST_IDLE: begin
          if (issue_s) begin
            opa_r          <= req_opa;
            opb_r          <= req_opb;
            div_unsigned_r <= req_unsigned;
            cnt_r          <= {CNT_W{1'b0}};
          end
        end
        ST_BUSY: begin
          // Operands stay untouched: the divider applies its sign fixup
          // combinationally from them for the whole run.
          if (cnt_r != CNT_MAX) begin
            cnt_r <= cnt_r + CNT_ONE;
          end
          if (div.div_done && !flush) begin
            hi_r <= div.div_result[63:32];
            lo_r <= div.div_result[31:0];
          end
          if (!div.div_done && (cnt_r == LIMIT_C)) begin
            timeout_r <= 1'b1;
          end
        end
        ST_HOLD: begin
          // Captured result is held until written or flushed.
        end
        default: begin
        end
      endcase
    end
  end

  assign div.div_start    = start_r;
  assign div.div_unsigned = div_unsigned_r;
  assign div.div_opa      = opa_r;
  assign div.div_opb      = opb_r;

  assign stall_req = stall_req_s;
  assign hilo_we   = hilo_we_s;
  assign busy      = busy_s;
  assign hi_out    = hi_r;
  assign lo_out    = lo_r;
  assign timeout   = timeout_r;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_div_issue_ctrl
//   Self-checking bench for div_issue_ctrl. A behavioural level-start
//   divider model answers the controller; a table of divisions with
//   hand-computed results is run through the controller, followed by
//   hand-written sequences for flush, backpressure, stale done, reset and
//   timeout.
// ---------------------------------------------------------------------------
module tb_div_issue_ctrl;
  localparam int DIV_CYCLES    = 36;
  localparam int TIMEOUT_SLACK = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_unsigned;
  logic [31:0] req_opa;
  logic [31:0] req_opb;
  logic        flush;
  logic        pipe_ready;
  logic        stall_req;
  logic        hilo_we;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic        busy;
  logic        timeout;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  div_issue_ctrl_if dif ();

  div_issue_ctrl #(
    .DIV_CYCLES   (DIV_CYCLES),
    .TIMEOUT_SLACK(TIMEOUT_SLACK)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_unsigned(req_unsigned),
    .req_opa     (req_opa),
    .req_opb     (req_opb),
    .flush       (flush),
    .pipe_ready  (pipe_ready),
    .stall_req   (stall_req),
    .hilo_we     (hilo_we),
    .hi_out      (hi_out),
    .lo_out      (lo_out),
    .busy        (busy),
    .timeout     (timeout),
    .div         (dif)
  );

  // Behavioural level-start divider: done rises after start has been high
  // for DIV_CYCLES cycles; dropping start clears it.
  int          mcnt = 0;
  logic        stuck = 1'b0;
  logic        stale_done = 1'b0;
  logic signed [31:0] sa, sb;
  logic [31:0] mq, mr;

  assign sa = dif.div_opa;
  assign sb = dif.div_opb;

  always @(posedge clock) begin
    if (!dif.div_start) mcnt <= 0;
    else if (mcnt != DIV_CYCLES) mcnt <= mcnt + 1;
  end

  always_comb begin
    mq = 32'hFFFF_FFFF;
    mr = dif.div_opa;
    if (dif.div_opb != 32'd0) begin
      if (dif.div_unsigned) begin
        mq = dif.div_opa / dif.div_opb;
        mr = dif.div_opa % dif.div_opb;
      end else begin
        mq = sa / sb;
        mr = sa % sb;
      end
    end
  end

  assign dif.div_result = {mr, mq};
  assign dif.div_done   = (dif.div_start && (mcnt == DIV_CYCLES) && !stuck) || stale_done;

  typedef struct packed {
    logic        u;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs [7];

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Present a request for one cycle; returns at the first BUSY-cycle sample.
  task automatic issue(input logic u, input logic [31:0] a, input logic [31:0] b);
    req_valid = 1'b1; req_unsigned = u; req_opa = a; req_opb = b;
    tick();
    req_valid = 1'b0; req_opa = 32'd0; req_opb = 32'd0;
  endtask

  // Full division with pipe_ready high, checking latency, stall window,
  // start-high window and the single HI/LO write.
  task automatic run_div(input logic u, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo, input int id);
    int stall_n = 0, start_n = 0, we_n = 0, we_idx = -1;
    logic [31:0] got_hi = 32'd0, got_lo = 32'd0;
    logic fin = 1'b0;
    pipe_ready = 1'b1;
    req_valid = 1'b1; req_unsigned = u; req_opa = a; req_opb = b;
    #1;
    if (stall_req) stall_n++;
    tick();
    req_valid = 1'b0; req_opa = 32'd0; req_opb = 32'd0;
    #1;
    for (int i = 0; i < 100; i++) begin
      if (stall_req) stall_n++;
      if (dif.div_start && !dif.div_done) start_n++;
      if (hilo_we) begin we_n++; got_hi = hi_out; got_lo = lo_out; we_idx = i; end
      if (!busy) begin fin = 1'b1; break; end
      tick();
    end
    check($sformatf("div%0d_finished", id), 64'(fin), 64'd1);
    check($sformatf("div%0d_we_count", id), 64'(we_n), 64'd1);
    check($sformatf("div%0d_we_cycle", id), 64'(we_idx), 64'(DIV_CYCLES + 1));
    check($sformatf("div%0d_start_cycles", id), 64'(start_n), 64'(DIV_CYCLES));
    check($sformatf("div%0d_stall_cycles", id), 64'(stall_n), 64'(DIV_CYCLES + 2));
    check($sformatf("div%0d_hi", id), 64'(got_hi), 64'(ehi));
    check($sformatf("div%0d_lo", id), 64'(got_lo), 64'(elo));
  endtask

  // Wait (bounded) for the HOLD state: busy with the stall released.
  task automatic wait_hold(input string nm);
    logic found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (busy && !stall_req) begin found = 1'b1; break; end
      tick();
    end
    check(nm, 64'(found), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{u: 1'b1, a: 32'd100,        b: 32'd7,          hi: 32'd2,          lo: 32'd14};
    vecs[1] = '{u: 1'b0, a: 32'hFFFF_FFF9,  b: 32'd2,          hi: 32'hFFFF_FFFF,  lo: 32'hFFFF_FFFD};
    vecs[2] = '{u: 1'b1, a: 32'hFFFF_FFFF,  b: 32'h10,         hi: 32'hF,          lo: 32'h0FFF_FFFF};
    vecs[3] = '{u: 1'b0, a: 32'd7,          b: 32'hFFFF_FFFE,  hi: 32'd1,          lo: 32'hFFFF_FFFD};
    vecs[4] = '{u: 1'b0, a: 32'hFFFF_FF9C,  b: 32'd7,          hi: 32'hFFFF_FFFE,  lo: 32'hFFFF_FFF2};
    vecs[5] = '{u: 1'b1, a: 32'h8000_0000,  b: 32'd2,          hi: 32'd0,          lo: 32'h4000_0000};
    vecs[6] = '{u: 1'b0, a: 32'h8000_0000,  b: 32'd2,          hi: 32'd0,          lo: 32'hC000_0000};

    reset = 1'b0; req_valid = 1'b0; req_unsigned = 1'b0; req_opa = 32'd0; req_opb = 32'd0;
    flush = 1'b0; pipe_ready = 1'b0;
    tick(); tick();
    check("rst_stall", 64'(stall_req), 64'd0);
    check("rst_hilo_we", 64'(hilo_we), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_start", 64'(dif.div_start), 64'd0);
    check("rst_timeout", 64'(timeout), 64'd0);
    check("rst_hilo", {hi_out, lo_out}, 64'd0);
    reset = 1'b1;
    tick();

    // Request killed by a flush in IDLE is ignored.
    req_valid = 1'b1; req_unsigned = 1'b1; req_opa = 32'd5; req_opb = 32'd1; flush = 1'b1;
    #1;
    check("idle_flush_stall", 64'(stall_req), 64'd0);
    tick();
    req_valid = 1'b0; flush = 1'b0;
    check("idle_flush_busy", 64'(busy), 64'd0);
    check("idle_flush_start", 64'(dif.div_start), 64'd0);

    // Table of divisions, back to back.
    for (int k = 0; k < 7; k++) begin
      run_div(vecs[k].u, vecs[k].a, vecs[k].b, vecs[k].hi, vecs[k].lo, k);
    end

    // Flush at BUSY cycle 10, then an immediate new request.
    issue(1'b1, 32'd100, 32'd7);
    for (int i = 0; i < 10; i++) tick();
    flush = 1'b1;
    #1;
    check("flush_busy_stall", 64'(stall_req), 64'd1);
    check("flush_busy_we", 64'(hilo_we), 64'd0);
    tick();
    flush = 1'b0;
    check("flush_busy_start_low", 64'(dif.div_start), 64'd0);
    check("flush_busy_idle", 64'(busy), 64'd0);
    check("flush_busy_stall_drop", 64'(stall_req), 64'd0);
    check("flush_busy_we2", 64'(hilo_we), 64'd0);
    run_div(1'b1, 32'd9, 32'd3, 32'd0, 32'd3, 10);

    // Backpressure in HOLD: 5 cycles with pipe_ready low.
    pipe_ready = 1'b0;
    issue(1'b1, 32'd1000, 32'd33);
    wait_hold("bp_reach_hold");
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_we_%0d", i), 64'(hilo_we), 64'd0);
      check($sformatf("bp_hilo_%0d", i), {hi_out, lo_out}, {32'd10, 32'd30});
      tick();
    end
    pipe_ready = 1'b1;
    #1;
    check("bp_release_we", 64'(hilo_we), 64'd1);
    check("bp_release_hilo", {hi_out, lo_out}, {32'd10, 32'd30});
    tick();
    check("bp_after_busy", 64'(busy), 64'd0);
    check("bp_after_we", 64'(hilo_we), 64'd0);

    // Flush during HOLD: no write.
    pipe_ready = 1'b0;
    issue(1'b1, 32'd50, 32'd5);
    wait_hold("hold_flush_reach");
    flush = 1'b1; pipe_ready = 1'b1;
    #1;
    check("hold_flush_we", 64'(hilo_we), 64'd0);
    tick();
    flush = 1'b0;
    check("hold_flush_idle", 64'(busy), 64'd0);
    check("hold_flush_we2", 64'(hilo_we), 64'd0);

    // Flush coinciding with div_done: nothing captured.
    begin
      logic seen = 1'b0;
      issue(1'b1, 32'd81, 32'd4);
      for (int i = 0; i < 100; i++) begin
        if (dif.div_done) begin seen = 1'b1; break; end
        tick();
      end
      check("done_flush_seen_done", 64'(seen), 64'd1);
    end
    flush = 1'b1;
    #1;
    check("done_flush_we", 64'(hilo_we), 64'd0);
    tick();
    flush = 1'b0;
    check("done_flush_idle", 64'(busy), 64'd0);
    check("done_flush_start", 64'(dif.div_start), 64'd0);
    check("done_flush_no_capture", {hi_out, lo_out}, {32'd0, 32'd10});
    tick();
    check("done_flush_we2", 64'(hilo_we), 64'd0);

    // Stale done in IDLE is ignored.
    stale_done = 1'b1;
    #1;
    check("stale_we", 64'(hilo_we), 64'd0);
    tick();
    check("stale_busy", 64'(busy), 64'd0);
    check("stale_we2", 64'(hilo_we), 64'd0);
    stale_done = 1'b0;
    tick();

    // Reset mid-BUSY.
    issue(1'b1, 32'd100, 32'd7);
    for (int i = 0; i < 5; i++) tick();
    reset = 1'b0;
    tick();
    check("midrst_start", 64'(dif.div_start), 64'd0);
    check("midrst_unsigned", 64'(dif.div_unsigned), 64'd0);
    check("midrst_ops", {dif.div_opa, dif.div_opb}, 64'd0);
    check("midrst_hilo", {hi_out, lo_out}, 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_stall", 64'(stall_req), 64'd0);
    check("midrst_we", 64'(hilo_we), 64'd0);
    check("midrst_timeout", 64'(timeout), 64'd0);
    reset = 1'b1;
    tick();

    // Timeout with done stuck low.
    stuck = 1'b1;
    issue(1'b1, 32'd5, 32'd1);
    for (int i = 0; i < DIV_CYCLES + TIMEOUT_SLACK; i++) tick();
    check("to_not_yet", 64'(timeout), 64'd0);
    tick();
    check("to_set", 64'(timeout), 64'd1);
    check("to_still_busy", 64'(busy), 64'd1);
    for (int i = 0; i < 5; i++) tick();
    check("to_sticky_busy", 64'(timeout), 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    stuck = 1'b0;
    check("to_flush_idle", 64'(busy), 64'd0);
    check("to_sticky_idle", 64'(timeout), 64'd1);
    run_div(1'b1, 32'd9, 32'd3, 32'd0, 32'd3, 11);
    check("to_sticky_after_op", 64'(timeout), 64'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("to_cleared_by_reset", 64'(timeout), 64'd0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
